line_burst_adaptor: RTL

Bridges the cache's 256-bit line interface to the 64-bit burst memory port. Converts a line read into four 64-bit burst beats assembled into one line, and a line write (eviction) into four 64-bit beats driven from the line. Sits between the cache datapath's line arrays and physical memory and runs one transaction at a time.

---
 rtl/line_burst_adaptor.sv | 114 +++++++++++
 1 files changed

// File: rtl/line_burst_adaptor.sv
// Bridges a wide cache line port to a narrow burst memory port, one transaction at a time.
// A line read gathers S_LINE/S_BURST beats into line_o; a line write streams the latched line out beat by beat.
module line_burst_adaptor #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_LINE-1:0]    line_i,
  output logic [S_LINE-1:0]    line_o,
  input  logic [31:0]          address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [S_BURST-1:0]   burst_i,
  output logic [S_BURST-1:0]   burst_o,
  output logic [31:0]          address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i,
  output logic [1:0]           state_o
);

  localparam int BEATS = S_LINE / S_BURST;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST       = KW'(BEATS - 1);
  localparam logic [31:0]   ALIGN_MASK = ~(32'(S_LINE / 8) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [31:0]                     addr_q, addr_d;
  logic [BEATS-1:0][S_BURST-1:0]   wline_q, wline_d;
  logic [BEATS-1:0][S_BURST-1:0]   rline_q, rline_d;

  // Handshake: read_i/write_i are levels held until resp_o; read_o/write_o stay high
  // until the last beat is acknowledged; each resp_i=1 cycle in RD/WR moves exactly one beat.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i & ALIGN_MASK;
          k_d     = '0;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = address_i & ALIGN_MASK;
          k_d     = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          rline_d[k_q] = burst_i;
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      WR: begin
        if (resp_i) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the partially assembled read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = rline_q;
  assign burst_o   = wline_q[k_q];
  assign state_o   = state_q;

endmodule
